mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester (IF) and a
// data-stage requester (D). Only one access is in flight at a time. A grant
// captures the winner's address, write data and operation. The captured values
// then drive the memory port until mem_rdy completes the access. Data wins
// ties by default.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to enable the starvation
// guard. After STARVE_MAX consecutive data grants issued while IF was waiting,
// IF wins the next contested arbitration.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   if_re, if_addr        fetch read request (held until if_rdy), fetch address
//   if_rdy, if_data       fetch completion pulse, fetch data (0 unless if_rdy)
//   d_re, d_we            data read / write request (held until d_rdy)
//   d_addr, d_wdata       data address, write data
//   d_rdy, d_rdata        data completion pulse, read data (0 unless d_rdy)
//   stall_if, stall_mem   stall for a fetch / data request still waiting
//   mem_addr, mem_wdata   shared memory address, write data
//   mem_re, mem_we        shared memory strobes
//   mem_rdata, mem_rdy    memory read data, access complete (latency >= 1)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_re,
    input  logic [15:0] if_addr,
    output logic        if_rdy,
    output logic [15:0] if_data,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_rdy,
    output logic [15:0] d_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [15:0] latAddr;
    logic [15:0] latWdata;
    logic        latWe;
    logic        dReq;
    logic        grantIf;
    logic        grantD;
    logic        starveHit;

    assign dReq = d_re | d_we;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

    logic [CNT_W-1:0] starveCnt;

    // The count never passes STARVE_MAX: at that value the next contested
    // arbitration goes to IF, and an IF grant clears the count.
    assign starveHit = (starveCnt >= CNT_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (grantIf) begin
            starveCnt <= '0;
        end else if (grantD) begin
            starveCnt <= if_re ? starveCnt + 1'b1 : '0;
        end
    end
`else
    // Fixed priority: data always wins. STARVE_MAX has no effect in this
    // build, so this expression is always false.
    assign starveHit = 1'b0 & (STARVE_MAX != 0);
`endif

    // State and grant capture. Requester inputs are sampled only on a grant,
    // so changes while busy never reach the memory port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            latAddr  <= '0;
            latWdata <= '0;
            latWe    <= 1'b0;
        end else begin
            state <= stateNext;
            if (grantIf) begin
                latAddr  <= if_addr;
                latWdata <= '0;
                latWe    <= 1'b0;
            end else if (grantD) begin
                latAddr  <= d_addr;
                latWdata <= d_wdata;
                latWe    <= d_we;       // a write wins over a simultaneous read
            end
        end
    end

    always_comb begin
        stateNext = state;
        grantIf   = 1'b0;
        grantD    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rdy    = 1'b0;
        d_rdy     = 1'b0;
        case (state)
            IDLE: begin
                // mem_rdy is ignored here: no access is outstanding.
                if (if_re && (!dReq || starveHit)) begin
                    grantIf   = 1'b1;
                    stateNext = IF_BUSY;
                end else if (dReq) begin
                    grantD    = 1'b1;
                    stateNext = D_BUSY;
                end
            end
            IF_BUSY: begin
                mem_re    = 1'b1;
                mem_addr  = latAddr;
                mem_wdata = latWdata;
                // A reset in the completing cycle abandons the access, so no
                // completion pulse is reported for it.
                if_rdy    = mem_rdy & ~rst;
                if (mem_rdy) stateNext = IDLE;
            end
            D_BUSY: begin
                mem_re    = ~latWe;
                mem_we    = latWe;
                mem_addr  = latAddr;
                mem_wdata = latWdata;
                d_rdy     = mem_rdy & ~rst;
                if (mem_rdy) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign if_data   = if_rdy ? mem_rdata : '0;
    assign d_rdata   = d_rdy  ? mem_rdata : '0;
    assign stall_if  = if_re & ~if_rdy;
    assign stall_mem = dReq & ~d_rdy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// The stimulus process drives the requesters, the memory responder and reset.
// It runs a transaction-level model of the arbiter. The model queues each
// expected memory access and each expected completion, tagged with the cycle
// it is due in. The monitor process samples the DUT on every falling edge and
// compares the DUT outputs against the queued expectations.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        if_re;
    logic [15:0] if_addr;
    logic        if_rdy;
    logic [15:0] if_data;
    logic        d_re;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_rdy;
    logic [15:0] d_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_rdy;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_re(if_re), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdy(d_rdy), .d_rdata(d_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        logic        re;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        int          cyc;
        bit          isIf;
        logic [15:0] data;
    } rdy_t;

    acc_t accQ[$];
    rdy_t rdyQ[$];

    int cyc       = 0;
    bit finishReq = 1'b0;

    // Transaction-level model state.
    bit mBusy    = 1'b0;
    bit mOwnerIf = 1'b0;
    int starve   = 0;
    bit ifDone   = 1'b0;
    bit dDone    = 1'b0;

    // Apply the inputs already set for this cycle to the model, then advance
    // one clock.
    task automatic step();
        bit dReq;
        dReq = d_re | d_we;
        if (!rst && mBusy && mem_rdy) begin
            rdyQ.push_back('{cyc: cyc, isIf: mOwnerIf, data: mem_rdata});
            if (mOwnerIf) ifDone = 1'b1;
            else          dDone  = 1'b1;
        end
        if (rst) begin
            mBusy  = 1'b0;
            starve = 0;
        end else if (mBusy) begin
            if (mem_rdy) mBusy = 1'b0;
        end else if (if_re && (!dReq || (GUARD && starve == STARVE_MAX))) begin
            accQ.push_back('{cyc: cyc + 1, re: 1'b1, we: 1'b0, addr: if_addr, wdata: 16'h0000});
            mBusy    = 1'b1;
            mOwnerIf = 1'b1;
            starve   = 0;
        end else if (dReq) begin
            accQ.push_back('{cyc: cyc + 1, re: !d_we, we: d_we, addr: d_addr, wdata: d_wdata});
            mBusy    = 1'b1;
            mOwnerIf = 1'b0;
            starve   = if_re ? starve + 1 : 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clearIns();
        if_re = 1'b0; if_addr = '0;
        d_re = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdy = 1'b0; mem_rdata = '0;
    endtask

    // Stimulus
    initial begin
        int op;
        rst = 1'b1;
        clearIns();
        @(posedge clk);
        #1;
        step(); step();
        rst = 1'b0;
        step(); step();

        // Lone fetch, memory answers one cycle after the strobe.
        if_re = 1'b1; if_addr = 16'h0010; step();
        mem_rdy = 1'b1; mem_rdata = 16'hABCD; step();
        clearIns(); step(); step();

        // Read and write together: the write wins.
        d_re = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h5555; step();
        mem_rdy = 1'b1; mem_rdata = 16'h7777; step();
        clearIns(); step();

        // Contention: data first, fetch in the following idle cycle.
        if_re = 1'b1; if_addr = 16'h0100; d_re = 1'b1; d_addr = 16'h0200; step();
        step();
        mem_rdy = 1'b1; mem_rdata = 16'h1111; step();
        d_re = 1'b0; mem_rdy = 1'b0; step();
        mem_rdy = 1'b1; mem_rdata = 16'h2222; step();
        clearIns(); step();

        // Slow memory: five wait cycles.
        d_re = 1'b1; d_addr = 16'h0444; step();
        for (int i = 0; i < 5; i++) begin
            mem_rdata = 16'($urandom);
            step();
        end
        mem_rdy = 1'b1; mem_rdata = 16'h4321; step();
        clearIns(); step();

        // Reset in the middle of a write; a late mem_rdy must be ignored.
        d_we = 1'b1; d_addr = 16'h0600; d_wdata = 16'h1234; step();
        step();
        rst = 1'b1; step();
        rst = 1'b0; clearIns(); mem_rdy = 1'b1; mem_rdata = 16'hDEAD; step(); step();
        clearIns(); step();

        // Both requesters held continuously.
        ifDone = 1'b0; dDone = 1'b0;
        if_re = 1'b1; d_re = 1'b1; d_we = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (ifDone) begin ifDone = 1'b0; if_addr = 16'($urandom); end
            if (dDone)  begin dDone  = 1'b0; d_addr  = 16'($urandom); end
            mem_rdy   = ($urandom_range(1) == 0);
            mem_rdata = 16'($urandom);
            step();
        end
        clearIns(); step(); step();

        // Random traffic with occasional resets and busy-time input changes.
        ifDone = 1'b0; dDone = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(199) == 0);
            if (ifDone || !if_re) begin
                ifDone  = 1'b0;
                if_re   = ($urandom_range(2) == 0);
                if_addr = 16'($urandom);
            end else if (mBusy && mOwnerIf && $urandom_range(3) == 0) begin
                if_addr = 16'($urandom);
            end
            if (dDone || !(d_re || d_we)) begin
                dDone = 1'b0;
                if ($urandom_range(1) == 0) begin
                    d_re = 1'b0; d_we = 1'b0;
                end else begin
                    op   = $urandom_range(2);
                    d_re = (op != 1);
                    d_we = (op != 0);
                end
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end else if (mBusy && !mOwnerIf && $urandom_range(3) == 0) begin
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end
            mem_rdy   = ($urandom_range(2) == 0);
            mem_rdata = 16'($urandom);
            step();
        end

        // Drain whatever is still in flight.
        rst = 1'b0;
        clearIns();
        mem_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_rdata = 16'($urandom);
            step();
        end
        clearIns(); step();
        finishReq = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        int   nCmp;
        int   nErr;
        acc_t cur;
        rdy_t r;
        bit   curValid;
        bit   endAcc;
        logic [33:0] expMem, gotMem;
        logic        expIfRdy, expDRdy;
        logic [15:0] expIfData, expDData;
        nCmp = 0; nErr = 0; curValid = 1'b0;
        cur = '{cyc: 0, re: 1'b0, we: 1'b0, addr: 16'h0, wdata: 16'h0};
        forever begin
            @(negedge clk);
            if (finishReq) begin
                nCmp++;
                if (accQ.size() != 0 || rdyQ.size() != 0) begin
                    nErr++;
                    $display("FAIL leftover: %0d accesses and %0d completions never seen, want 0 and 0",
                             accQ.size(), rdyQ.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
                $finish;
            end
            if (cyc >= 1) begin
                if (accQ.size() > 0 && accQ[0].cyc == cyc) begin
                    cur      = accQ.pop_front();
                    curValid = 1'b1;
                end
                expMem = curValid ? {cur.re, cur.we, cur.addr, cur.wdata} : '0;
                gotMem = {mem_re, mem_we, mem_addr, mem_wdata};
                nCmp++;
                if (gotMem !== expMem) begin
                    nErr++;
                    $display("FAIL memport cyc=%0d got re=%b we=%b addr=%h wdata=%h want re=%b we=%b addr=%h wdata=%h",
                             cyc, mem_re, mem_we, mem_addr, mem_wdata,
                             expMem[33], expMem[32], expMem[31:16], expMem[15:0]);
                end

                expIfRdy = 1'b0; expDRdy = 1'b0; expIfData = '0; expDData = '0;
                endAcc = 1'b0;
                if (rdyQ.size() > 0 && rdyQ[0].cyc == cyc) begin
                    r = rdyQ.pop_front();
                    endAcc = 1'b1;
                    if (r.isIf) begin expIfRdy = 1'b1; expIfData = r.data; end
                    else        begin expDRdy  = 1'b1; expDData  = r.data; end
                end
                nCmp++;
                if ({if_rdy, d_rdy, if_data, d_rdata} !== {expIfRdy, expDRdy, expIfData, expDData}) begin
                    nErr++;
                    $display("FAIL completion cyc=%0d got if_rdy=%b d_rdy=%b if_data=%h d_rdata=%h want if_rdy=%b d_rdy=%b if_data=%h d_rdata=%h",
                             cyc, if_rdy, d_rdy, if_data, d_rdata, expIfRdy, expDRdy, expIfData, expDData);
                end

                nCmp++;
                if ({stall_if, stall_mem} !== {if_re & ~expIfRdy, (d_re | d_we) & ~expDRdy}) begin
                    nErr++;
                    $display("FAIL stall cyc=%0d got stall_if=%b stall_mem=%b want stall_if=%b stall_mem=%b",
                             cyc, stall_if, stall_mem, if_re & ~expIfRdy, (d_re | d_we) & ~expDRdy);
                end

                if (endAcc || rst) curValid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary, want completion within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
